// File: rtl/regfile_dump_reader.sv
// Debug readout engine: walks register-file read port 2 from FIRST_REG to LAST_REG
// and streams (index, value) beats over valid/ready. Optional: REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [4:0]        rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
`ifdef REGFILE_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              done
);

  localparam logic [4:0] FIRST_L = 5'(FIRST_REG);
  localparam logic [4:0] LAST_L  = 5'(LAST_REG);

  typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

  state_t            state_q, state_d;
  logic [4:0]        idx_q, idx_d;
  logic [4:0]        rf_addr_q, rf_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [4:0]        out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rf_addr_d   = rf_addr_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    checksum_d  = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          idx_d     = FIRST_L;
          rf_addr_d = FIRST_L;
          busy_d    = 1'b1;
          state_d   = READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
      READ: begin
        out_data_d  = rf_data;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          checksum_d  = checksum_q + out_data_q;
`endif
          if (idx_q == LAST_L) begin
            state_d = FIN;
          end else begin
            idx_d     = idx_q + 5'd1;
            rf_addr_d = idx_q + 5'd1;
            state_d   = READ;
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything above, including a same-cycle beat acceptance.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      idx_d       = idx_q;
      rf_addr_d   = rf_addr_q;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      checksum_d  = checksum_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= FIRST_L;
      rf_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rf_addr_q   <= rf_addr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      checksum_q  <= checksum_d;
`endif
    end
  end

  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  assign checksum  = checksum_q;
`endif

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug readout engine on the register file's second read port.
- On `start`, walks register addresses FIRST_REG..LAST_REG and streams each (index, value) pair out over a valid/ready handshake, e.g. to a trace UART or bench monitor.
- Read side complementing the writeback-driven write port; no modification of architectural state.

Parameters:
- FIRST_REG, 0, first register index dumped (0..31).
- LAST_REG, 31, last register index dumped (FIRST_REG..31).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to begin a dump; ignored unless idle.
- abort  input  1  synchronous cancel; returns to idle without done.
- rf_addr  output  5  read address to register file port.
- rf_data  input  DATA_W  combinational read data for rf_addr.
- out_valid  output  1  out_index/out_data valid.
- out_ready  input  1  consumer accepts beat when high with out_valid.
- out_index  output  5  register index of current beat.
- out_data  output  DATA_W  register value of current beat.
- busy  output  1  high from accepted start until done/abort.
- done  output  1  one-cycle pulse after final beat accepted.

Behaviour:
- Reset (async, rst=1): state IDLE; rf_addr=0, out_valid=0, out_index=0, out_data=0, busy=0, done=0, internal idx=FIRST_REG (checksum=0 if enabled). Reset mid-dump discards it; no done.
- States: IDLE, READ, SEND, FIN.
  - IDLE: start=1 -> idx<=FIRST_REG, busy<=1, go READ.
  - READ: rf_addr=idx; at posedge capture out_data<=rf_data, out_index<=idx, out_valid<=1, go SEND.
  - SEND: hold out_valid/out_index/out_data stable until out_ready=1.
    - On accept: out_valid<=0.
    - If idx==LAST_REG, go FIN.
    - Otherwise idx<=idx+1 and go READ.
  - FIN: done<=1 for exactly one cycle, busy<=0, go IDLE.
- Latency:
  - start seen at posedge N -> first READ at cycle N+1 -> out_valid high from N+2.
  - With out_ready tied high: one beat per 2 cycles; done pulses 2*(LAST_REG-FIRST_REG+1)+1 cycles after start.
- rf_addr updates at posedge. Register file writes land on negedge, so the value sampled reflects any write completed in the preceding half-cycle.
- Dump is not an atomic snapshot; each value is as of its own READ cycle.
- Values are reported raw, including index 0; no masking of x0.
- start while busy: ignored.
- abort (any state other than IDLE): next posedge -> IDLE, out_valid=0, busy=0, done=0. abort has priority over out_ready acceptance in the same cycle.
- start and abort together while IDLE: abort wins; stay IDLE.
- FIRST_REG==LAST_REG: single beat, then done.
- idx never increments past LAST_REG; no wrap.
- rf_addr holds last driven value when not in READ.

Optional Feature:
- Macro: REGFILE_DUMP_CHECKSUM_EN.
- With macro defined: extra output port `checksum`, width DATA_W.
  - Cleared to 0 on reset and on accepted start.
  - On each accepted beat: checksum <= checksum + out_data, mod 2^DATA_W.
  - Holds its final value from the done pulse until the next start.
- Without macro: port and accumulator absent; all other behaviour identical.

Test Plan:
- Preload x1=0x00000011, x2=0xDEADBEEF, others 0; start, out_ready=1, defaults -> 32 beats in order, indices 0..31, beat 2 data=0xDEADBEEF; done pulses once at cycle start+65; busy low afterwards.
- FIRST_REG=5, LAST_REG=7, x5..x7=5,6,7.
  - out_ready toggles 0,0,1 repeatedly -> data/index stable while stalled; exactly 3 beats (5,6,7).
  - With checksum enabled -> checksum=18.
- Assert abort while SEND on index 3 -> next cycle out_valid=0, busy=0, no done; new start afterwards dumps from FIRST_REG again.
- Assert async rst mid-dump (between clock edges) -> all outputs 0 immediately, state IDLE; start after release gives full normal dump.
- Pulse start again while busy at index 10 -> ignored; sequence continues 11,12,…, single done.
- Negedge writeback of x4=0x12345678 in the half-cycle before the READ of index 4 -> beat 4 carries 0x12345678.
